// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encoding and byte-lane geometry.
package dmem_pkg;

  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int WORD_W    = LANE_W * NUM_LANES;

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge for single-cycle read-modify-write: enabled lanes
// come from the write data, the rest from the current memory word.
module dmem_byte_merge
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0]    wdata,
  input  logic [WORD_W-1:0]    rdata,
  input  logic [NUM_LANES-1:0] be,
  output logic [WORD_W-1:0]    merged
);

  always_comb begin
    merged = rdata;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (be[i]) merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with bus lock and owner-idle timeout.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; default is fixed priority to requester 0.
//
// state | meaning
// ARB   | no lock held; arbitrate between requesters
// LOCK0 | requester 0 owns the memory; requester 1 waits
// LOCK1 | requester 1 owns the memory; requester 0 waits
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [3:0]  r0_be,
  input  logic        r0_lock,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [3:0]  r1_be,
  input  logic        r1_lock,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic             gnt0, gnt1, gnt_any, sel, pref1, owner_req;
  logic             oor0, oor1, g_oor, g_we, g_lock;
  logic [3:0]       g_be;
  logic [29:0]      g_word;
  logic [31:0]      g_wdata, merged;
  logic             addr_lsb_unused;

  // Byte offset bits play no part in word-addressed memory.
  assign addr_lsb_unused = &{1'b0, r0_addr[1:0], r1_addr[1:0]};

  assign oor0 = |r0_addr[31:ADDR_BITS+2];
  assign oor1 = |r1_addr[31:ADDR_BITS+2];

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       pref1 <= 1'b0;
    else if (gnt_any) pref1 <= ~sel;
  end
`else
  assign pref1 = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        LOCK0:   gnt0 = r0_req;
        LOCK1:   gnt1 = r1_req;
        default: begin
          if (r0_req && r1_req) begin
            gnt0 = ~pref1;
            gnt1 = pref1;
          end else begin
            gnt0 = r0_req;
            gnt1 = r1_req;
          end
        end
      endcase
    end
  end

  assign r0_gnt  = gnt0;
  assign r1_gnt  = gnt1;
  assign gnt_any = gnt0 | gnt1;
  assign sel     = gnt1;

  assign g_we    = sel ? r1_we          : r0_we;
  assign g_be    = sel ? r1_be          : r0_be;
  assign g_lock  = sel ? r1_lock        : r0_lock;
  assign g_word  = sel ? r1_addr[31:2]  : r0_addr[31:2];
  assign g_wdata = sel ? r1_wdata       : r0_wdata;
  assign g_oor   = sel ? oor1           : oor0;

  dmem_byte_merge u_merge (
    .wdata  (g_wdata),
    .rdata  (mem_rd),
    .be     (g_be),
    .merged (merged)
  );

  assign mem_a  = gnt_any ? {2'b00, g_word} : 32'd0;
  assign mem_wd = gnt_any ? merged : 32'd0;
  assign mem_we = gnt_any & g_we & (|g_be) & ~g_oor;

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = '0;
    owner_req    = (state == LOCK1) ? r1_req : r0_req;
    case (state)
      ARB: begin
        if (gnt_any && g_lock) state_nxt = sel ? LOCK1 : LOCK0;
      end
      LOCK0, LOCK1: begin
        if (owner_req) begin
          if (!g_lock) state_nxt = ARB;
        end else begin
          idle_cnt_nxt = (idle_cnt == CNT_MAX) ? CNT_MAX : idle_cnt + 1'b1;
          if (idle_cnt_nxt == CNT_MAX) state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB;
      idle_cnt  <= '0;
      r0_rvalid <= 1'b0;
      r0_err    <= 1'b0;
      r0_rdata  <= '0;
      r1_rvalid <= 1'b0;
      r1_err    <= 1'b0;
      r1_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      idle_cnt  <= idle_cnt_nxt;
      r0_rvalid <= gnt0;
      r0_err    <= gnt0 & oor0;
      r1_rvalid <= gnt1;
      r1_err    <= gnt1 & oor1;
      if (gnt0) r0_rdata <= oor0 ? 32'd0 : mem_rd;
      if (gnt1) r1_rdata <= oor1 ? 32'd0 : mem_rd;
    end
  end

endmodule
